// File: rtl/fft64_frame_loader.sv
// fft64_frame_loader: collects streamed complex samples into N-sample
// frames and presents each complete frame as one flat word to the FFT core.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_valid/s_ready     sample handshake; s_data = {re, im}
//   s_last              marks sample N-1 of a frame
//   frame_valid/ready   frame handshake toward the FFT core
//   frame_data          sample k at [W*k +: W], arrival order
//   frame_err           one-cycle pulse per dropped frame
//   drop_cnt            saturating dropped-frame counter
module fft64_frame_loader #(
    parameter int N = 64,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    input  logic           s_last,
    output logic           frame_valid,
    input  logic           frame_ready,
    output logic [N*W-1:0] frame_data,
    output logic           frame_err,
    output logic [7:0]     drop_cnt
);

    localparam int PW = $clog2(N);

    typedef enum logic {
        COLLECT = 1'b0,
        RESYNC  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [PW-1:0] wr_ptr;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;

    logic [W-1:0]  mem [2][N];

    logic          acc;
    logic          cons;
    logic          at_end;
    logic          complete;
    logic          drop;
    logic          store;

    assign acc    = s_valid & s_ready;
    assign cons   = frame_valid & frame_ready;
    assign at_end = (wr_ptr == PW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (1'b1)
            (state == COLLECT): begin
                if (acc && at_end && !s_last) begin
                    state_nx = RESYNC;
                end
            end
            (state == RESYNC): begin
                if (acc && s_last) begin
                    state_nx = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    // Output / event decode. s_ready depends on registered state only.
    always_comb begin
        s_ready  = 1'b0;
        store    = 1'b0;
        complete = 1'b0;
        drop     = 1'b0;
        if (rst_n) begin
            s_ready = (state == RESYNC) | ~full[wr_bank];
        end
        if (acc && state == COLLECT) begin
            store    = 1'b1;
            complete = at_end & s_last;
            // early last or missing last
            drop     = at_end ^ s_last;
        end
    end

    // Bank bookkeeping, error pulse and drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            frame_err <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            frame_err <= drop;
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (acc) begin
                if (store && !at_end && !s_last) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end else begin
                    wr_ptr <= '0;
                end
            end
            if (complete) begin
                wr_bank <= ~wr_bank;
            end
            if (cons) begin
                rd_bank <= ~rd_bank;
            end
            // Completion only targets a non-full bank, so it never
            // collides with the bank being consumed.
            for (int b = 0; b < 2; b++) begin
                full[b] <= (full[b] & ~(cons & (rd_bank == b[0])))
                         | (complete & (wr_bank == b[0]));
            end
        end
    end

    // Sample storage; not reset
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_bank][wr_ptr] <= s_data;
        end
    end

    assign frame_valid = full[rd_bank];

    always_comb begin
        frame_data = '0;
        for (int k = 0; k < N; k++) begin
            frame_data[W*k +: W] = mem[rd_bank][k];
        end
    end

endmodule

// File: tb/tb_fft64_frame_loader.sv
// tb_fft64_frame_loader: directed stimulus with a queue-based frame model
// compared against the loader every cycle, plus literal spot checks.
module tb_fft64_frame_loader;

    localparam int N = 64;
    localparam int W = 32;

    typedef logic [N*W-1:0] frame_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic           s_last = 1'b0;
    logic           frame_valid;
    logic           frame_ready = 1'b0;
    logic [N*W-1:0] frame_data;
    logic           frame_err;
    logic [7:0]     drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft64_frame_loader #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .drop_cnt    (drop_cnt)
    );

    // Model: FIFO of complete frames (at most two held), partial frame.
    frame_t       pend[$];
    logic [W-1:0] part[$];
    bit           resync = 1'b0;
    bit           m_err = 1'b0;
    int           m_cnt = 0;
    bit           en = 1'b0;

    function automatic bit m_ready();
        return rst_n && (resync || pend.size() < 2);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(posedge clk) begin : model
        bit hs;
        bit cons;
        frame_t f;
        if (!rst_n) begin
            pend.delete();
            part.delete();
            resync = 1'b0;
            m_err = 1'b0;
            m_cnt = 0;
            en = 1'b1;
        end else begin
            hs = s_valid && m_ready();
            cons = (pend.size() > 0) && frame_ready;
            m_err = 1'b0;
            if (cons) void'(pend.pop_front());
            if (hs) begin
                if (resync) begin
                    if (s_last) resync = 1'b0;
                end else begin
                    part.push_back(s_data);
                    if (part.size() == N || s_last) begin
                        if (part.size() == N && s_last) begin
                            for (int k = 0; k < N; k++) f[W*k +: W] = part[k];
                            pend.push_back(f);
                        end else begin
                            m_err = 1'b1;
                            if (m_cnt < 255) m_cnt++;
                            if (part.size() == N) resync = 1'b1;
                        end
                        part.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        frame_t e;
        if (en) begin
            chk("s_ready", 32'(s_ready), 32'(m_ready()));
            chk("frame_valid", 32'(frame_valid), 32'(pend.size() > 0));
            chk("frame_err", 32'(frame_err), 32'(m_err));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
            if (pend.size() > 0) begin
                e = pend[0];
                if (frame_data !== e) begin
                    for (int k = 0; k < N; k++) begin
                        if (frame_data[W*k +: W] !== e[W*k +: W]) begin
                            chk($sformatf("frame_data[%0d]", k),
                                frame_data[W*k +: W], e[W*k +: W]);
                            break;
                        end
                    end
                end else begin
                    chk("frame_data", frame_data[31:0], e[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] wd(int k);
        return frame_data[W*k +: W];
    endfunction

    function automatic logic [W-1:0] mk(int base, int k);
        logic [15:0] v;
        v = 16'(base + k);
        return {v, -v};
    endfunction

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [W-1:0] d, bit last);
        bit r;
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        do begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 200);
        if (!r) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: got no s_ready expected s_ready within 200 cycles");
        end
    endtask

    task automatic send_seq(int base, int cnt, int last_idx);
        for (int k = 0; k < cnt; k++) send(mk(base, k), k == last_idx);
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    task automatic pulse_ready();
        frame_ready = 1'b1;
        cyc(1);
        frame_ready = 1'b0;
    endtask

    initial begin
        // Test 1: single frame, reset values, latency, stability
        cyc(1);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        send_seq(0, 64, 63);
        idle();
        chk("t1_valid", 32'(frame_valid), 32'd1);
        chk("t1_w0", wd(0), 32'h0000_0000);
        chk("t1_w5", wd(5), 32'h0005_FFFB);
        chk("t1_w63", wd(63), 32'h003F_FFC1);
        cyc(20);
        chk("t1_w63_stable", wd(63), 32'h003F_FFC1);
        pulse_ready();
        chk("t1_consumed", 32'(frame_valid), 32'd0);

        // Test 2: both banks full, back-pressure, FIFO order
        do_reset();
        send_seq(32'h100, 64, 63);
        send_seq(32'h200, 64, 63);
        s_valid = 1'b1;
        s_data = mk(32'h300, 0);
        s_last = 1'b0;
        cyc(3);
        chk("t2_stall", 32'(s_ready), 32'd0);
        chk("t2_f0_w0", wd(0), 32'h0100_FF00);
        pulse_ready();
        chk("t2_ready_back", 32'(s_ready), 32'd1);
        chk("t2_f1_w0", wd(0), 32'h0200_FE00);
        send_seq(32'h300, 64, 63);
        idle();
        pulse_ready();
        chk("t2_f2_w0", wd(0), 32'h0300_FD00);
        chk("t2_f2_w63", wd(63), 32'h033F_FCC1);
        pulse_ready();
        chk("t2_empty", 32'(frame_valid), 32'd0);

        // Test 3: early last
        do_reset();
        send_seq(32'h400, 11, 10);
        idle();
        chk("t3_err", 32'(frame_err), 32'd1);
        chk("t3_cnt", 32'(drop_cnt), 32'd1);
        cyc(1);
        chk("t3_err_pulse", 32'(frame_err), 32'd0);
        send_seq(32'h500, 64, 63);
        idle();
        chk("t3_valid", 32'(frame_valid), 32'd1);
        chk("t3_w0", wd(0), 32'h0500_FB00);
        pulse_ready();

        // Test 4: missing last, resync
        do_reset();
        send_seq(32'h600, 64, -1);
        idle();
        chk("t4_err", 32'(frame_err), 32'd1);
        chk("t4_cnt", 32'(drop_cnt), 32'd1);
        send_seq(32'h700, 5, 4);
        idle();
        cyc(1);
        chk("t4_cnt_resync", 32'(drop_cnt), 32'd1);
        chk("t4_no_frame", 32'(frame_valid), 32'd0);
        send_seq(32'h800, 64, 63);
        idle();
        chk("t4_w0", wd(0), 32'h0800_F800);
        pulse_ready();

        // Test 5: reset mid-frame and while presenting
        do_reset();
        send_seq(32'h900, 30, -1);
        idle();
        do_reset();
        chk("t5_valid", 32'(frame_valid), 32'd0);
        chk("t5_cnt", 32'(drop_cnt), 32'd0);
        send_seq(32'hA00, 64, 63);
        idle();
        chk("t5_w1", wd(1), 32'h0A01_F5FF);
        do_reset();
        chk("t5_valid2", 32'(frame_valid), 32'd0);
        send_seq(32'hB00, 64, 63);
        idle();
        chk("t5_w0", wd(0), 32'h0B00_F500);
        pulse_ready();

        // Test 6: completion and consume together, then saturation
        do_reset();
        send_seq(32'hC00, 64, 63);
        send_seq(32'hD00, 63, -1);
        s_valid = 1'b1;
        s_data = mk(32'hD00, 63);
        s_last = 1'b1;
        frame_ready = 1'b1;
        cyc(1);
        frame_ready = 1'b0;
        idle();
        chk("t6_valid", 32'(frame_valid), 32'd1);
        chk("t6_w0", wd(0), 32'h0D00_F300);
        pulse_ready();
        chk("t6_empty", 32'(frame_valid), 32'd0);
        for (int i = 0; i < 300; i++) send(mk(32'hE00, i), 1'b1);
        idle();
        cyc(1);
        chk("t6_sat", 32'(drop_cnt), 32'd255);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
